// File: rtl/gshare_branch_predictor.sv
// ---------------------------------------------------------------------------
// gshare_branch_predictor
//
// Purpose:
//   Next-PC predictor for the IF stage. Combines a global branch history
//   shift register, a pattern history table (PHT) of saturating counters and
//   a direct-mapped, tagged branch target buffer (BTB). The direction mode is
//   selectable at runtime: static not-taken, bimodal (PC-indexed PHT) or
//   gshare (PC xor history). Training updates arrive from the EX stage and
//   are applied on the rising clock edge. Saturating counters track how many
//   updates were accepted and how many of those reported a misprediction.
//
// Ports:
//   clk                clock, all state updates on the rising edge
//   reset_n            asynchronous active-low reset
//   mode               0 static-NT, 1 bimodal, 2 gshare, 3 behaves as gshare
//   current_pc         fetch PC to predict
//   predicted_pc       predicted next PC (combinational)
//   pred_taken         prediction is taken (combinational)
//   btb_hit            valid BTB entry with matching tag for current_pc
//   update_valid       apply training this cycle
//   update_pc          PC of the resolved control instruction
//   update_is_branch   resolved instruction is a conditional branch
//   update_is_jump     resolved instruction is an unconditional jump
//   update_taken       resolved direction
//   update_target      resolved target address
//   update_mispredict  the earlier prediction for this instruction was wrong
//   stat_updates       saturating count of accepted updates
//   stat_mispredicts   saturating count of accepted mispredicted updates
// ---------------------------------------------------------------------------
module gshare_branch_predictor #(
    parameter int HIST_WIDTH      = 5,
    parameter int BTB_INDEX_WIDTH = 5,
    parameter int CTR_WIDTH       = 2,
    parameter int STAT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            mode,
    input  logic [31:0]           current_pc,
    output logic [31:0]           predicted_pc,
    output logic                  pred_taken,
    output logic                  btb_hit,
    input  logic                  update_valid,
    input  logic [31:0]           update_pc,
    input  logic                  update_is_branch,
    input  logic                  update_is_jump,
    input  logic                  update_taken,
    input  logic [31:0]           update_target,
    input  logic                  update_mispredict,
    output logic [STAT_WIDTH-1:0] stat_updates,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);

    localparam int PHT_ENTRIES = 1 << HIST_WIDTH;
    localparam int BTB_ENTRIES = 1 << BTB_INDEX_WIDTH;
    localparam int TAG_WIDTH   = 32 - BTB_INDEX_WIDTH - 2;

    // Weak not-taken: MSB clear, all lower bits set.
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

    typedef enum logic [1:0] {
        MODE_STATIC   = 2'd0,
        MODE_BIMODAL  = 2'd1,
        MODE_GSHARE   = 2'd2,
        MODE_RESERVED = 2'd3
    } predMode_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [HIST_WIDTH-1:0]  r_bhsr;
    logic [CTR_WIDTH-1:0]   r_pht       [PHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] r_btbValid;
    logic [TAG_WIDTH-1:0]   r_btbTag    [BTB_ENTRIES];
    logic [31:0]            r_btbTarget [BTB_ENTRIES];
    logic [BTB_ENTRIES-1:0] r_btbJump;
    logic [STAT_WIDTH-1:0]  r_statUpdates;
    logic [STAT_WIDTH-1:0]  r_statMispredicts;

    // -----------------------------------------------------------------------
    // Mode decode
    // -----------------------------------------------------------------------
    predMode_t w_mode;
    logic      w_useHistory;
    logic      w_staticMode;

    assign w_mode       = predMode_t'(mode);
    // The reserved encoding is treated exactly like gshare.
    assign w_useHistory = (w_mode == MODE_GSHARE) || (w_mode == MODE_RESERVED);
    assign w_staticMode = (w_mode == MODE_STATIC);

    // -----------------------------------------------------------------------
    // Prediction path (purely combinational, reads registered state only)
    // -----------------------------------------------------------------------
    logic [HIST_WIDTH-1:0]      w_predPidx;
    logic [HIST_WIDTH-1:0]      w_predPhtIdx;
    logic [BTB_INDEX_WIDTH-1:0] w_predBidx;
    logic [TAG_WIDTH-1:0]       w_predTag;
    logic [CTR_WIDTH-1:0]       w_predCtr;
    logic                       w_predHit;
    logic                       w_predDirTaken;

    assign w_predPidx   = current_pc[HIST_WIDTH+1:2];
    assign w_predBidx   = current_pc[BTB_INDEX_WIDTH+1:2];
    assign w_predTag    = current_pc[31:BTB_INDEX_WIDTH+2];
    assign w_predPhtIdx = w_useHistory ? (w_predPidx ^ r_bhsr) : w_predPidx;
    assign w_predCtr    = r_pht[w_predPhtIdx];

    assign w_predHit      = r_btbValid[w_predBidx] && (r_btbTag[w_predBidx] == w_predTag);
    // Jumps are always taken once known; branches follow the counter MSB.
    assign w_predDirTaken = r_btbJump[w_predBidx] || w_predCtr[CTR_WIDTH-1];

    assign btb_hit      = w_predHit;
    assign pred_taken   = !w_staticMode && w_predHit && w_predDirTaken;
    assign predicted_pc = pred_taken ? r_btbTarget[w_predBidx] : (current_pc + 32'd4);

    // -----------------------------------------------------------------------
    // Update path decode
    // -----------------------------------------------------------------------
    logic [HIST_WIDTH-1:0]      w_updPidx;
    logic [HIST_WIDTH-1:0]      w_updPhtIdx;
    logic [BTB_INDEX_WIDTH-1:0] w_updBidx;
    logic [TAG_WIDTH-1:0]       w_updTag;
    logic [CTR_WIDTH-1:0]       w_updCtr;
    logic [CTR_WIDTH-1:0]       w_updCtrNext;
    logic                       w_branchUpdate;
    logic                       w_btbWrite;

    assign w_updPidx   = update_pc[HIST_WIDTH+1:2];
    assign w_updBidx   = update_pc[BTB_INDEX_WIDTH+1:2];
    assign w_updTag    = update_pc[31:BTB_INDEX_WIDTH+2];
    // Training uses the same mode-dependent index the lookup would have used
    // with the history as it stands before this edge.
    assign w_updPhtIdx = w_useHistory ? (w_updPidx ^ r_bhsr) : w_updPidx;
    assign w_updCtr    = r_pht[w_updPhtIdx];

    // A jump flag wins over a branch flag when both are set.
    assign w_branchUpdate = update_valid && update_is_branch && !update_is_jump;
    assign w_btbWrite     = update_valid && (update_is_jump || (update_is_branch && update_taken));

    // Saturating counter step for the selected PHT entry.
    always_comb begin
        w_updCtrNext = w_updCtr;
        if (update_taken) begin
            if (w_updCtr != CTR_MAX) begin
                w_updCtrNext = w_updCtr + CTR_ONE;
            end
        end else begin
            if (w_updCtr != '0) begin
                w_updCtrNext = w_updCtr - CTR_ONE;
            end
        end
    end

    // Global history: every resolved conditional branch shifts in its
    // direction regardless of mode, so gshare starts with a warm history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bhsr <= '0;
        end else if (w_branchUpdate) begin
            r_bhsr <= {r_bhsr[HIST_WIDTH-2:0], update_taken};
        end
    end

    // Pattern history table: every counter returns to weak not-taken on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                r_pht[i] <= CTR_INIT;
            end
        end else if (w_branchUpdate) begin
            r_pht[w_updPhtIdx] <= w_updCtrNext;
        end
    end

    // BTB valid and jump bits. Only the valid bits need a reset value; an
    // invalid entry never contributes to a prediction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btbValid <= '0;
            r_btbJump  <= '0;
        end else if (w_btbWrite) begin
            r_btbValid[w_updBidx] <= 1'b1;
            r_btbJump[w_updBidx]  <= update_is_jump;
        end
    end

    // BTB tag and target payload. Direct-mapped: a new tag simply overwrites.
    always_ff @(posedge clk) begin
        if (w_btbWrite) begin
            r_btbTag[w_updBidx]    <= w_updTag;
            r_btbTarget[w_updBidx] <= update_target;
        end
    end

    // Statistics: count every accepted update, saturating at all-ones so a
    // long run never wraps back to a misleadingly small number.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_statUpdates     <= '0;
            r_statMispredicts <= '0;
        end else if (update_valid) begin
            if (r_statUpdates != STAT_MAX) begin
                r_statUpdates <= r_statUpdates + STAT_ONE;
            end
            if (update_mispredict && (r_statMispredicts != STAT_MAX)) begin
                r_statMispredicts <= r_statMispredicts + STAT_ONE;
            end
        end
    end

    assign stat_updates     = r_statUpdates;
    assign stat_mispredicts = r_statMispredicts;

    // The byte-offset bits of both PCs carry no information for a
    // word-aligned predictor.
    logic w_unusedPcBits;
    assign w_unusedPcBits = ^{current_pc[1:0], update_pc[1:0]};

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_gshare_branch_predictor
//
// Self-checking bench for gshare_branch_predictor with default parameters.
// Directed scenarios from the behaviour description plus a randomized run
// compared against a table-level reference model.
// ---------------------------------------------------------------------------
module tb_gshare_branch_predictor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  mode;
    logic [31:0] current_pc;
    logic [31:0] predicted_pc;
    logic        pred_taken;
    logic        btb_hit;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_is_branch;
    logic        update_is_jump;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispredict;
    logic [15:0] stat_updates;
    logic [15:0] stat_mispredicts;

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays indexed by word address arithmetic.
    int          mPht    [32];
    bit          mValid  [32];
    int unsigned mTag    [32];
    int unsigned mTarget [32];
    bit          mJump   [32];
    int          mBhsr;
    int          mUpd;
    int          mMis;

    always #5 clk = ~clk;

    gshare_branch_predictor dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .mode              (mode),
        .current_pc        (current_pc),
        .predicted_pc      (predicted_pc),
        .pred_taken        (pred_taken),
        .btb_hit           (btb_hit),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_is_branch  (update_is_branch),
        .update_is_jump    (update_is_jump),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_mispredict (update_mispredict),
        .stat_updates      (stat_updates),
        .stat_mispredicts  (stat_mispredicts)
    );

    // Model reset: counters weak not-taken, BTB empty, history and stats clear.
    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            mPht[i]   = 1;
            mValid[i] = 1'b0;
            mJump[i]  = 1'b0;
        end
        mBhsr = 0;
        mUpd  = 0;
        mMis  = 0;
    endtask

    function automatic void modelPredict(input int unsigned pc, input int md,
                                         output int unsigned pPc, output bit pTk,
                                         output bit pHit);
        int slot;
        int idx;
        slot = int'((pc / 4) % 32);
        idx  = (md >= 2) ? (slot ^ mBhsr) : slot;
        pHit = mValid[slot] && (mTag[slot] == pc / 128);
        pTk  = (md != 0) && pHit && (mJump[slot] || mPht[idx] >= 2);
        pPc  = pTk ? mTarget[slot] : pc + 32'd4;
    endfunction

    task automatic modelUpdate(input int unsigned pc, input int md, input bit br,
                               input bit jmp, input bit tk, input int unsigned tgt,
                               input bit mis);
        int slot;
        int idx;
        slot = int'((pc / 4) % 32);
        if (mUpd < 65535) mUpd++;
        if (mis && mMis < 65535) mMis++;
        if (jmp) begin
            mValid[slot] = 1'b1; mTag[slot] = pc / 128; mTarget[slot] = tgt; mJump[slot] = 1'b1;
        end else if (br) begin
            idx = (md >= 2) ? (slot ^ mBhsr) : slot;
            if (tk) mPht[idx] = (mPht[idx] < 3) ? mPht[idx] + 1 : 3;
            else    mPht[idx] = (mPht[idx] > 0) ? mPht[idx] - 1 : 0;
            mBhsr = (mBhsr * 2 + (tk ? 1 : 0)) % 32;
            if (tk) begin
                mValid[slot] = 1'b1; mTag[slot] = pc / 128; mTarget[slot] = tgt; mJump[slot] = 1'b0;
            end
        end
    endtask

    task automatic applyReset();
        reset_n      = 1'b0;
        update_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        modelReset();
    endtask

    // One training update applied on a single rising edge.
    task automatic applyStimulus(input logic [31:0] pc, input bit br, input bit jmp,
                                 input bit tk, input logic [31:0] tgt, input bit mis);
        @(negedge clk);
        update_pc         = pc;
        update_is_branch  = br;
        update_is_jump    = jmp;
        update_taken      = tk;
        update_target     = tgt;
        update_mispredict = mis;
        update_valid      = 1'b1;
        @(posedge clk);
        modelUpdate(pc, int'(mode), br, jmp, tk, tgt, mis);
        #1;
        update_valid = 1'b0;
    endtask

    task automatic test_reset();
        mode = 2'd2;
        current_pc = 32'h100;
        applyReset();
        #1;
        checks++; if (predicted_pc !== 32'h104) begin errors++; $display("[TB] FAIL reset_pc got %h want %h", predicted_pc, 32'h104); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_taken got %b want 0", pred_taken); end
        checks++; if (btb_hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit got %b want 0", btb_hit); end
        checks++; if (stat_updates !== 16'h0 || stat_mispredicts !== 16'h0) begin errors++; $display("[TB] FAIL reset_stats got %h/%h want 0/0", stat_updates, stat_mispredicts); end
        current_pc = 32'hFFFF_FFFC;
        #1;
        checks++; if (predicted_pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc got %h want 00000000", predicted_pc); end
    endtask

    task automatic test_bimodal();
        applyReset();
        mode = 2'd1;
        applyStimulus(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1);
        current_pc = 32'h100;
        #1;
        checks++; if (predicted_pc !== 32'h80) begin errors++; $display("[TB] FAIL bimodal_pc got %h want %h", predicted_pc, 32'h80); end
        checks++; if (pred_taken !== 1'b1 || btb_hit !== 1'b1) begin errors++; $display("[TB] FAIL bimodal_flags got %b%b want 11", pred_taken, btb_hit); end
        checks++; if (stat_updates !== 16'd1 || stat_mispredicts !== 16'd1) begin errors++; $display("[TB] FAIL bimodal_stats got %0d/%0d want 1/1", stat_updates, stat_mispredicts); end
    endtask

    task automatic test_gshare();
        applyReset();
        mode = 2'd2;
        applyStimulus(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1);
        current_pc = 32'h100;
        #1;
        checks++; if (predicted_pc !== 32'h104 || pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL gshare_pc got %h/%b want 00000104/0", predicted_pc, pred_taken); end
        checks++; if (btb_hit !== 1'b1) begin errors++; $display("[TB] FAIL gshare_hit got %b want 1", btb_hit); end
        mode = 2'd1;
        #1;
        checks++; if (predicted_pc !== 32'h80) begin errors++; $display("[TB] FAIL gshare_to_bimodal got %h want %h", predicted_pc, 32'h80); end
        mode = 2'd3;
        #1;
        checks++; if (predicted_pc !== 32'h104) begin errors++; $display("[TB] FAIL mode3_pc got %h want %h", predicted_pc, 32'h104); end
    endtask

    task automatic test_jump();
        // Continues from the gshare state; 0x200 shares BTB slot 0 with 0x100.
        mode = 2'd1;
        applyStimulus(32'h200, 1'b0, 1'b1, 1'b0, 32'h400, 1'b0);
        mode = 2'd2;
        current_pc = 32'h200;
        #1;
        checks++; if (predicted_pc !== 32'h400 || pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL jump_pc got %h/%b want 00000400/1", predicted_pc, pred_taken); end
        mode = 2'd0;
        #1;
        checks++; if (predicted_pc !== 32'h204 || btb_hit !== 1'b1) begin errors++; $display("[TB] FAIL static_pc got %h/%b want 00000204/1", predicted_pc, btb_hit); end
        current_pc = 32'h100;
        #1;
        checks++; if (btb_hit !== 1'b0) begin errors++; $display("[TB] FAIL jump_evict got %b want 0", btb_hit); end
        checks++; if (stat_updates !== 16'd2 || stat_mispredicts !== 16'd1) begin errors++; $display("[TB] FAIL jump_stats got %0d/%0d want 2/1", stat_updates, stat_mispredicts); end
    endtask

    task automatic test_alias();
        applyReset();
        mode = 2'd1;
        applyStimulus(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
        current_pc = 32'h180;
        #1;
        checks++; if (btb_hit !== 1'b0 || predicted_pc !== 32'h184) begin errors++; $display("[TB] FAIL alias_miss got %b/%h want 0/00000184", btb_hit, predicted_pc); end
        applyStimulus(32'h180, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0);
        current_pc = 32'h100;
        #1;
        checks++; if (btb_hit !== 1'b0 || predicted_pc !== 32'h104) begin errors++; $display("[TB] FAIL alias_evict got %b/%h want 0/00000104", btb_hit, predicted_pc); end
        current_pc = 32'h180;
        #1;
        checks++; if (predicted_pc !== 32'h300) begin errors++; $display("[TB] FAIL alias_new got %h want %h", predicted_pc, 32'h300); end
    endtask

    task automatic test_ctr_saturation();
        applyReset();
        mode = 2'd1;
        // Counter at 1: three not-taken must stop at 0, so one taken gives 1.
        for (int i = 0; i < 3; i++) applyStimulus(32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
        current_pc = 32'h100;
        #1;
        checks++; if (pred_taken !== 1'b0 || predicted_pc !== 32'h104) begin errors++; $display("[TB] FAIL ctr_floor got %b/%h want 0/00000104", pred_taken, predicted_pc); end
        // Five taken must stop at 3, so one not-taken gives 2 (still taken).
        for (int i = 0; i < 5; i++) applyStimulus(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
        applyStimulus(32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        current_pc = 32'h100;
        #1;
        checks++; if (pred_taken !== 1'b1 || predicted_pc !== 32'h80) begin errors++; $display("[TB] FAIL ctr_ceiling got %b/%h want 1/00000080", pred_taken, predicted_pc); end
    endtask

    task automatic test_random_back_to_back();
        int unsigned qpc;
        int unsigned ePc;
        bit eTk;
        bit eHit;
        applyReset();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) qpc = 32'hFFFF_FF80 | ($urandom_range(0, 31) << 2);
            else qpc = ($urandom_range(0, 2) << 7) | ($urandom_range(0, 7) << 2);
            current_pc        = qpc;
            update_valid      = ($urandom_range(0, 3) != 0);
            update_pc         = ($urandom_range(0, 2) << 7) | ($urandom_range(0, 7) << 2);
            update_is_branch  = 1'($urandom_range(0, 1));
            update_is_jump    = ($urandom_range(0, 4) == 0);
            update_taken      = 1'($urandom_range(0, 1));
            update_target     = $urandom & 32'hFFFF_FFFC;
            update_mispredict = 1'($urandom_range(0, 1));
            #1;
            modelPredict(qpc, int'(mode), ePc, eTk, eHit);
            checks++; if (predicted_pc !== ePc) begin errors++; $display("[TB] FAIL rand_pc n=%0d pc=%h got %h want %h", n, qpc, predicted_pc, ePc); end
            checks++; if (pred_taken !== eTk || btb_hit !== eHit) begin errors++; $display("[TB] FAIL rand_flags n=%0d got %b%b want %b%b", n, pred_taken, btb_hit, eTk, eHit); end
            checks++; if (stat_updates !== 16'(mUpd) || stat_mispredicts !== 16'(mMis)) begin errors++; $display("[TB] FAIL rand_stats n=%0d got %0d/%0d want %0d/%0d", n, stat_updates, stat_mispredicts, mUpd, mMis); end
            @(posedge clk);
            if (update_valid) modelUpdate(update_pc, int'(mode), update_is_branch, update_is_jump, update_taken, update_target, update_mispredict);
        end
        @(negedge clk);
        update_valid = 1'b0;
    endtask

    task automatic test_stat_saturation();
        applyReset();
        mode = 2'd1;
        @(negedge clk);
        update_pc         = 32'h40;
        update_is_branch  = 1'b0;
        update_is_jump    = 1'b0;
        update_taken      = 1'b0;
        update_target     = 32'h0;
        update_mispredict = 1'b0;
        update_valid      = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        update_mispredict = 1'b1;
        repeat (65530) @(posedge clk);
        @(negedge clk);
        update_valid = 1'b0;
        checks++; if (stat_updates !== 16'hFFFF) begin errors++; $display("[TB] FAIL stat_sat got %h want FFFF", stat_updates); end
        checks++; if (stat_mispredicts !== 16'hFFFA) begin errors++; $display("[TB] FAIL stat_mis got %h want FFFA", stat_mispredicts); end
        current_pc = 32'h40;
        #1;
        checks++; if (btb_hit !== 1'b0) begin errors++; $display("[TB] FAIL noflag_table got %b want 0", btb_hit); end
    endtask

    task automatic test_reset_midcycle();
        applyReset();
        mode = 2'd1;
        applyStimulus(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1);
        current_pc = 32'h100;
        #1;
        checks++; if (predicted_pc !== 32'h80) begin errors++; $display("[TB] FAIL pre_reset got %h want %h", predicted_pc, 32'h80); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (predicted_pc !== 32'h104 || btb_hit !== 1'b0 || stat_updates !== 16'h0) begin errors++; $display("[TB] FAIL async_reset got %h/%b/%0d want 00000104/0/0", predicted_pc, btb_hit, stat_updates); end
        // An update held across an edge while in reset must be lost.
        update_pc         = 32'h100;
        update_is_branch  = 1'b1;
        update_is_jump    = 1'b0;
        update_taken      = 1'b1;
        update_target     = 32'h80;
        update_mispredict = 1'b1;
        update_valid      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        update_valid = 1'b0;
        reset_n      = 1'b1;
        modelReset();
        #1;
        checks++; if (stat_updates !== 16'h0 || btb_hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_edge_update got %0d/%b want 0/0", stat_updates, btb_hit); end
    endtask

    initial begin
        reset_n           = 1'b0;
        mode              = 2'd0;
        current_pc        = 32'h0;
        update_valid      = 1'b0;
        update_pc         = 32'h0;
        update_is_branch  = 1'b0;
        update_is_jump    = 1'b0;
        update_taken      = 1'b0;
        update_target     = 32'h0;
        update_mispredict = 1'b0;
        modelReset();
        test_reset();
        test_bimodal();
        test_gshare();
        test_jump();
        test_alias();
        test_ctr_saturation();
        test_random_back_to_back();
        test_stat_saturation();
        test_reset_midcycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
